// File: rtl/mux_uart_multi.sv
// Multi-channel MUX UART: per channel a TX FIFO feeding an 8N1 serialiser,
// a one-byte RX holding register, status/control registers and a shared
// active-low interrupt request. Channel n occupies BASE_ADDR+2n (status/control)
// and BASE_ADDR+2n+1 (RX data / TX data).
module mux_uart_multi #(
  parameter int          CHANNELS     = 4,
  parameter logic [18:0] BASE_ADDR    = 19'h3f200,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [3:0]  IRQ_LEVEL    = 4'd6
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [18:0]           address,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  output logic                  sel,
  input  logic [CHANNELS-1:0]   rx_valid,
  input  logic [8*CHANNELS-1:0] rx_data,
  output logic [CHANNELS-1:0]   tx_serial,
  output logic [CHANNELS-1:0]   tx_load,
  output logic [8*CHANNELS-1:0] tx_data,
  output logic                  int_reqn,
  output logic [3:0]            irq_number
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                CNT_W     = PTR_W + 1;
  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [18:0]       WIN       = 19'(2 * CHANNELS);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

  // Serialiser state
  tx_state_e         state_q [CHANNELS];
  tx_state_e         state_d [CHANNELS];
  logic [BAUD_W-1:0] baud_q  [CHANNELS];
  logic [BAUD_W-1:0] baud_d  [CHANNELS];
  logic [2:0]        bit_q   [CHANNELS];
  logic [2:0]        bit_d   [CHANNELS];
  logic [7:0]        shift_q [CHANNELS];
  logic [7:0]        shift_d [CHANNELS];

  // TX FIFO
  logic [7:0]       fifo_mem_q [CHANNELS][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q   [CHANNELS];
  logic [PTR_W-1:0] rd_ptr_q   [CHANNELS];
  logic [CNT_W-1:0] cnt_q      [CHANNELS];
  logic [7:0]       head       [CHANNELS];

  // RX, flags and enables
  logic [7:0]          rx_hold_q [CHANNELS];
  logic [CHANNELS-1:0] rx_full_q, rx_ovr_q, tx_ovf_q, rx_ie_q, tx_ie_q;
  logic                int_reqn_q;

  // Decoded strobes and per-channel status
  logic [18:0]         offset;
  logic [2:0]          ch_sel;
  logic                is_data;
  logic [CHANNELS-1:0] ctrl_wr, data_wr, data_rd, fifo_full, push, pop, tx_idle;
  logic [7:0]          status [CHANNELS];

  assign offset     = address - BASE_ADDR;
  assign sel        = (address >= BASE_ADDR) && (offset < WIN);
  assign ch_sel     = offset[3:1];
  assign is_data    = offset[0];
  assign irq_number = IRQ_LEVEL;
  assign int_reqn   = int_reqn_q;

  // Bus decode, FIFO flags and status assembly per channel
  // NOTE: every output of an always_comb gets a default before any branch, so no latch is inferred.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      ctrl_wr[c]   = write_en && sel && (ch_sel == 3'(c)) && !is_data;
      data_wr[c]   = write_en && sel && (ch_sel == 3'(c)) && is_data;
      data_rd[c]   = read_en  && sel && (ch_sel == 3'(c)) && is_data;
      fifo_full[c] = (cnt_q[c] == FULL_CNT);
      push[c]      = data_wr[c] && !fifo_full[c];
      tx_idle[c]   = (cnt_q[c] == '0) && (state_q[c] == S_IDLE);
      head[c]      = fifo_mem_q[c][rd_ptr_q[c]];
      status[c]    = {3'b000, tx_ovf_q[c], rx_ovr_q[c], tx_idle[c], !fifo_full[c], rx_full_q[c]};
    end
  end

  // Read mux: status on even addresses, held RX byte on odd, zero outside the window
  always_comb begin
    data_out = 8'h00;
    for (int c = 0; c < CHANNELS; c++) begin
      if (sel && (ch_sel == 3'(c))) data_out = is_data ? rx_hold_q[c] : status[c];
    end
  end

  // Serialiser next state, FIFO pop and line outputs
  always_comb begin
    tx_serial = '1;
    tx_load   = '0;
    tx_data   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      baud_d[c]  = baud_q[c];
      bit_d[c]   = bit_q[c];
      shift_d[c] = shift_q[c];
      pop[c]     = 1'b0;
      unique case (state_q[c])
        S_IDLE: begin
          if (cnt_q[c] != '0) begin
            pop[c]     = 1'b1;
            state_d[c] = S_START;
            baud_d[c]  = '0;
            shift_d[c] = head[c];
          end
        end
        S_START: begin
          tx_serial[c] = 1'b0;
          if (baud_q[c] == BAUD_LAST) begin
            baud_d[c]  = '0;
            bit_d[c]   = 3'd0;
            state_d[c] = S_DATA;
          end else baud_d[c] = baud_q[c] + BAUD_W'(1);
        end
        S_DATA: begin
          tx_serial[c] = shift_q[c][0];
          if (baud_q[c] == BAUD_LAST) begin
            baud_d[c]  = '0;
            shift_d[c] = shift_q[c] >> 1;
            if (bit_q[c] == 3'd7) state_d[c] = S_STOP;
            else                  bit_d[c]   = bit_q[c] + 3'd1;
          end else baud_d[c] = baud_q[c] + BAUD_W'(1);
        end
        S_STOP: begin
          if (baud_q[c] == BAUD_LAST) begin
            baud_d[c] = '0;
            // Next byte loads on the stop-bit's final edge so frames run back-to-back
            if (cnt_q[c] != '0) begin
              pop[c]     = 1'b1;
              state_d[c] = S_START;
              shift_d[c] = head[c];
            end else state_d[c] = S_IDLE;
          end else baud_d[c] = baud_q[c] + BAUD_W'(1);
        end
        default: state_d[c] = S_IDLE;
      endcase
      tx_load[c]         = pop[c];
      tx_data[8*c +: 8]  = pop[c] ? head[c] : 8'h00;
    end
  end

  // Serialiser and FIFO pointer registers
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c]  <= S_IDLE;
        baud_q[c]   <= '0;
        bit_q[c]    <= '0;
        shift_q[c]  <= '0;
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c]  <= state_d[c];
        baud_q[c]   <= baud_d[c];
        bit_q[c]    <= bit_d[c];
        shift_q[c]  <= shift_d[c];
        wr_ptr_q[c] <= wr_ptr_q[c] + PTR_W'(push[c]);
        rd_ptr_q[c] <= rd_ptr_q[c] + PTR_W'(pop[c]);
        cnt_q[c]    <= cnt_q[c] + CNT_W'(push[c]) - CNT_W'(pop[c]);
      end
    end
  end

  // FIFO storage write port
  // NOTE: FIFO storage has no reset; emptiness is defined by the pointers and count alone.
  always_ff @(posedge clock) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (push[c]) fifo_mem_q[c][wr_ptr_q[c]] <= data_in;
    end
  end

  // Control, sticky flags and RX holding register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rx_full_q <= '0;
      rx_ovr_q  <= '0;
      tx_ovf_q  <= '0;
      rx_ie_q   <= '0;
      tx_ie_q   <= '0;
      for (int c = 0; c < CHANNELS; c++) rx_hold_q[c] <= 8'h00;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (ctrl_wr[c]) begin
          rx_ie_q[c] <= data_in[0];
          tx_ie_q[c] <= data_in[1];
          if (data_in[3]) begin
            rx_ovr_q[c] <= 1'b0;
            tx_ovf_q[c] <= 1'b0;
          end
        end
        // A new error event in the clear cycle wins over the clear
        if (data_wr[c] && fifo_full[c]) tx_ovf_q[c] <= 1'b1;
        if (rx_valid[c]) begin
          if (!rx_full_q[c] || data_rd[c]) begin
            rx_hold_q[c] <= rx_data[8*c +: 8];
            rx_full_q[c] <= 1'b1;
          end else rx_ovr_q[c] <= 1'b1;
        end else if (data_rd[c]) begin
          rx_full_q[c] <= 1'b0;
        end
      end
    end
  end

  // Registered interrupt request, one cycle behind its condition
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) int_reqn_q <= 1'b1;
    else         int_reqn_q <= !(|((rx_ie_q & rx_full_q) | (tx_ie_q & tx_idle)));
  end

endmodule

// File: tb/tb_mux_uart_multi.sv
// Directed bench for mux_uart_multi with CHANNELS=4, CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_mux_uart_multi;

  localparam logic [18:0] BASE = 19'h3f200;

  logic        clock = 1'b0;
  logic        resetn;
  logic [18:0] address;
  logic        write_en, read_en;
  logic [7:0]  data_in, data_out;
  logic        sel;
  logic [3:0]  rx_valid;
  logic [31:0] rx_data;
  logic [3:0]  tx_serial, tx_load;
  logic [31:0] tx_data;
  logic        int_reqn;
  logic [3:0]  irq_number;

  int n_cmp = 0;
  int n_err = 0;

  mux_uart_multi #(
    .CHANNELS(4), .BASE_ADDR(BASE), .FIFO_DEPTH(4), .CLKS_PER_BIT(4), .IRQ_LEVEL(4'd6)
  ) dut (
    .clock(clock), .resetn(resetn), .address(address), .write_en(write_en),
    .read_en(read_en), .data_in(data_in), .data_out(data_out), .sel(sel),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_serial(tx_serial), .tx_load(tx_load),
    .tx_data(tx_data), .int_reqn(int_reqn), .irq_number(irq_number)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; the DUT samples them at the next rising edge
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic status_is(input int ch, input logic [7:0] exp, input string tag);
    address  = BASE + 19'(2 * ch);
    write_en = 1'b0;
    read_en  = 1'b0;
    #1;
    check(tag, {24'h0, data_out}, {24'h0, exp});
    address = 19'h0;
  endtask

  task automatic bus_write(input logic [18:0] a, input logic [7:0] d);
    address  = a;
    data_in  = d;
    write_en = 1'b1;
    tick();
    write_en = 1'b0;
    address  = 19'h0;
  endtask

  initial begin
    logic [9:0] frame;
    logic [7:0] b;
    logic       exp_load;
    int         k;
    int         n_loads;

    resetn = 1'b0; address = 19'h0; write_en = 1'b0; read_en = 1'b0;
    data_in = 8'h00; rx_valid = 4'h0; rx_data = 32'h0;

    // 1. Reset state
    #1;
    check("rst_serial_during", {28'h0, tx_serial}, 32'hf);
    tick(); tick();
    resetn = 1'b1;
    #1;
    check("rst_serial", {28'h0, tx_serial}, 32'hf);
    check("rst_load", {28'h0, tx_load}, 32'h0);
    check("rst_txdata", tx_data, 32'h0);
    check("rst_intn", {31'h0, int_reqn}, 32'h1);
    check("irq_number", {28'h0, irq_number}, 32'h6);
    for (int c = 0; c < 4; c++) status_is(c, 8'h06, "rst_status");
    address = 19'h3f208; #1;
    check("sel_above", {31'h0, sel}, 32'h0);
    check("dout_outside", {24'h0, data_out}, 32'h0);
    address = 19'h3f1ff; #1;
    check("sel_below", {31'h0, sel}, 32'h0);
    address = 19'h3f207; #1;
    check("sel_last", {31'h0, sel}, 32'h1);
    address = 19'h0;

    // 2. Single byte 0x48 on channel 0
    bus_write(BASE + 19'd1, 8'h48);
    #1;
    check("t2_load", {31'h0, tx_load[0]}, 32'h1);
    check("t2_data", {24'h0, tx_data[7:0]}, 32'h48);
    check("t2_line_idle", {31'h0, tx_serial[0]}, 32'h1);
    status_is(0, 8'h02, "t2_status_queued");
    frame = 10'b1010010000;
    for (int i = 0; i < 40; i++) begin
      tick();
      check("t2_serial", {31'h0, tx_serial[0]}, {31'h0, frame[i/4]});
      if (i == 0) check("t2_load_once", {31'h0, tx_load[0]}, 32'h0);
      if (i == 20) status_is(0, 8'h02, "t2_status_busy");
    end
    tick();
    status_is(0, 8'h06, "t2_status_done");
    check("t2_line_after", {31'h0, tx_serial[0]}, 32'h1);

    // 3. Burst of six writes into a four-deep FIFO on channel 2
    for (int t = 0; t < 205; t++) begin
      if (t < 6) begin
        address = BASE + 19'd5; data_in = 8'(8'h31 + t); write_en = 1'b1;
      end else begin
        address = 19'h0; write_en = 1'b0;
      end
      #1;
      exp_load = (t >= 1) && (t <= 161) && (((t - 1) % 40) == 0);
      check("t3_load", {31'h0, tx_load[2]}, {31'h0, exp_load});
      if (exp_load) check("t3_data", {24'h0, tx_data[23:16]}, {24'h0, 8'(8'h31 + (t - 1) / 40)});
      if (t >= 2 && t < 202) begin
        k     = t - 2;
        b     = 8'(8'h31 + k / 40);
        frame = {1'b1, b, 1'b0};
        check("t3_serial", {31'h0, tx_serial[2]}, {31'h0, frame[(k % 40) / 4]});
      end else begin
        check("t3_serial_idle", {31'h0, tx_serial[2]}, 32'h1);
      end
      if (t == 6) status_is(2, 8'h10, "t3_status_full");
      tick();
    end
    status_is(2, 8'h16, "t3_status_ovf");
    bus_write(BASE + 19'd4, 8'h08);
    status_is(2, 8'h06, "t3_status_cleared");

    // 4. RX interrupt on channel 1
    bus_write(BASE + 19'd2, 8'h01);
    rx_valid = 4'b0010; rx_data[15:8] = 8'h41;
    tick();
    rx_valid = 4'h0;
    #1;
    check("t4_intn_lag", {31'h0, int_reqn}, 32'h1);
    status_is(1, 8'h07, "t4_status_full");
    tick();
    check("t4_intn_low", {31'h0, int_reqn}, 32'h0);
    address = BASE + 19'd3; read_en = 1'b1; #1;
    check("t4_rx_byte", {24'h0, data_out}, 32'h41);
    tick();
    read_en = 1'b0;
    status_is(1, 8'h06, "t4_status_read");
    check("t4_intn_still_low", {31'h0, int_reqn}, 32'h0);
    tick();
    check("t4_intn_high", {31'h0, int_reqn}, 32'h1);

    // 5. Overrun and coincident pop/receive on channel 3
    rx_valid = 4'b1000; rx_data[31:24] = 8'h11; tick();
    rx_data[31:24] = 8'h22; tick();
    rx_valid = 4'h0;
    status_is(3, 8'h0f, "t5_status_overrun");
    address = BASE + 19'd7; read_en = 1'b1; #1;
    check("t5_rx_old", {24'h0, data_out}, 32'h11);
    tick();
    read_en = 1'b0;
    status_is(3, 8'h0e, "t5_status_empty");
    bus_write(BASE + 19'd6, 8'h08);
    status_is(3, 8'h06, "t5_status_clr");
    rx_valid = 4'b1000; rx_data[31:24] = 8'h44; tick();
    rx_valid = 4'h0;
    status_is(3, 8'h07, "t5_status_44");
    address = BASE + 19'd7; read_en = 1'b1;
    rx_valid = 4'b1000; rx_data[31:24] = 8'h55; #1;
    check("t5_rx_44", {24'h0, data_out}, 32'h44);
    tick();
    rx_valid = 4'h0; read_en = 1'b0;
    status_is(3, 8'h07, "t5_status_coincident");
    address = BASE + 19'd7; #1;
    check("t5_rx_55", {24'h0, data_out}, 32'h55);
    read_en = 1'b1; tick(); read_en = 1'b0;
    address = BASE + 19'd7; read_en = 1'b1; #1;
    check("t5_rx_empty_read", {24'h0, data_out}, 32'h55);
    tick(); read_en = 1'b0;
    status_is(3, 8'h06, "t5_status_final");
    check("t5_intn", {31'h0, int_reqn}, 32'h1);

    // 6. Reset in the middle of a channel-0 frame with two bytes queued
    for (int j = 0; j < 3; j++) bus_write(BASE + 19'd1, 8'(8'ha0 + j));
    check("t6_line_start", {31'h0, tx_serial[0]}, 32'h0);
    status_is(0, 8'h02, "t6_status_busy");
    resetn = 1'b0; #1;
    check("t6_line_abort", {31'h0, tx_serial[0]}, 32'h1);
    check("t6_load_abort", {28'h0, tx_load}, 32'h0);
    check("t6_intn_abort", {31'h0, int_reqn}, 32'h1);
    tick(); tick();
    resetn = 1'b1;
    n_loads = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (tx_load != 4'h0) n_loads++;
      tick();
    end
    check("t6_no_load", n_loads, 0);
    check("t6_line_idle", {28'h0, tx_serial}, 32'hf);
    for (int c = 0; c < 4; c++) status_is(c, 8'h06, "t6_status");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_uart_multi.md
Name: mux_uart_multi

Overview:
- Parametrised multi-channel MUX UART peripheral for the CPU6 test bench and system.
- Generalises the single print-on-write UART at 0x3f201 to CHANNELS channels. Each channel has a TX FIFO, an 8N1 serialiser, an RX holding register, status/control registers and interrupt generation.
- Sits on the CPU6 19-bit address bus beside Memory. Drives `sel` so the bus read mux can pick `data_out`.

Parameters:
- CHANNELS, 4, number of channels (1-8).
- BASE_ADDR, 19'h3f200, address of channel 0 status register.
- FIFO_DEPTH, 8, TX FIFO entries per channel (power of 2, >=2).
- CLKS_PER_BIT, 16, clock cycles per serial bit (>=2).
- IRQ_LEVEL, 4'd6, value driven on `irq_number`.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- address  in  19  CPU bus address.
- write_en  in  1  bus write strobe.
- read_en  in  1  bus read strobe; qualifies read side effects.
- data_in  in  8  write data.
- data_out  out  8  read data; combinational.
- sel  out  1  address is inside this block's window; combinational.
- rx_valid  in  CHANNELS  one-cycle receive strobe per channel.
- rx_data  in  8*CHANNELS  receive byte; channel n at [8n+7:8n].
- tx_serial  out  CHANNELS  8N1 serial output; idle high.
- tx_load  out  CHANNELS  one-cycle pulse when a byte enters the shifter.
- tx_data  out  8*CHANNELS  byte loaded into the shifter; valid with `tx_load`.
- int_reqn  out  1  active-low interrupt request, registered.
- irq_number  out  4  constant IRQ_LEVEL.

Behaviour:
- Address map, channel n:
  - BASE_ADDR+2n: read = status, write = control.
  - BASE_ADDR+2n+1: read = RX data, write = TX data.
  - `sel` = 1 for addresses in [BASE_ADDR, BASE_ADDR+2*CHANNELS).
  - `data_out` = 0 when `sel` = 0.
- Status bits:
  - b0 RX full.
  - b1 TX FIFO not full.
  - b2 TX idle (FIFO empty and shifter idle).
  - b3 RX overrun (sticky).
  - b4 TX overflow (sticky).
  - b7..b5 = 0.
- Control write:
  - b0 RX interrupt enable.
  - b1 TX-idle interrupt enable.
  - b3 = 1 clears b3 and b4 of status.
  - Other bits ignored.
  - Control is write-only; reading that address returns status.
- Reset (resetn low, asynchronous):
  - FIFOs empty, shifters idle, RX empty, sticky flags and enables cleared.
  - `tx_serial` all 1, `tx_load` 0, `tx_data` 0, `int_reqn` 1.
  - Status reads 0x06.
  - Reset mid-frame aborts the frame: line high immediately, FIFO contents discarded.
- TX FIFO push: `write_en` to a data address.
  - If the registered count == FIFO_DEPTH, the byte is dropped and b4 set, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle are allowed when not full.
- Serialiser states: IDLE, START, DATA, STOP.
  - IDLE with FIFO non-empty: pop and go to START on the next edge; `tx_load` pulses that cycle.
  - Write at edge N into an empty FIFO with an idle shifter: `tx_load` high in cycle N+1, start bit begins at N+1.
  - Frame = start 0, data bits LSB first, stop 1. Each bit lasts exactly CLKS_PER_BIT cycles; 10*CLKS_PER_BIT per frame.
  - At the end of STOP with FIFO non-empty: the next byte loads on the same edge, so frames are contiguous with no idle gap.
- RX register:
  - `rx_valid` with RX empty: store the byte, set b0.
  - `rx_valid` with RX full: set b3, discard the new byte, keep the old one.
  - `read_en` on a data address while `sel`: `data_out` shows the held byte; at the edge, clear b0.
  - Pop and `rx_valid` in the same cycle: the new byte is stored, b0 stays 1, no overrun.
  - Read of an empty RX returns the last byte, no effect.
  - Status reads have no side effects.
- `int_reqn` registered, one cycle after its condition:
  - Low if any channel has (RX int enable & b0) or (TX-idle int enable & b2).

Test Plan (CHANNELS=4, BASE_ADDR=0x3f200, CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Reset pulse -> status 0x3f200..0x3f206 all read 0x06; `tx_serial`=4'b1111; `int_reqn`=1; `sel`=0 at 0x3f208.
2. Write 0x48 to 0x3f201 -> `tx_load[0]` pulses next cycle with `tx_data`=0x48; `tx_serial[0]` = 0,0,0,0,1,0,0,1,0,1, 4 cycles each (40 total); status 0x02 during the frame, 0x06 afterward.
3. Write 0x31..0x36 to 0x3f205 on 6 consecutive cycles -> bytes 0x31..0x35 sent back-to-back with no gap, 0x36 dropped, status 0x3f204 b4=1; control write 0x08 -> b4=0.
4. Control 0x3f202 <= 0x01, then `rx_valid[1]` with 0x41 -> `int_reqn` low one cycle later, status 0x07; read 0x3f203 with `read_en` -> 0x41, status 0x06, `int_reqn` high the cycle after.
5. `rx_valid[3]` 0x11, then 0x22 with no read -> read 0x3f207 returns 0x11, status b3=1; `rx_valid` coincident with pop -> new byte held, no overrun.
6. Assert resetn low mid-frame on channel 0 with 2 bytes queued -> `tx_serial[0]`=1 immediately; after release, no `tx_load`, status 0x06.
